// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready inter-stage register with a 2-entry skid buffer and OR-ed multi-source flush.
// Defining PIPE_STAGE_PERF_EN adds saturating stall/bubble/flush counters.
module pipe_stage_skid #(
    parameter int DATA_W         = 256,
    parameter int FLUSH_N        = 3,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int PERF_W         = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    input  logic [FLUSH_N-1:0] flush,
    output logic [1:0]         occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PERF_W-1:0]  stall_cnt,
    output logic [PERF_W-1:0]  bubble_cnt,
    output logic [PERF_W-1:0]  flush_cnt
`endif
);

    logic              main_valid_r, skid_valid_r;
    logic [DATA_W-1:0] main_data_r, skid_data_r;
    logic              in_ready_r;
    logic [1:0]        occupancy_r;

    logic              main_valid_s, skid_valid_s;
    logic [DATA_W-1:0] main_data_s, skid_data_s;
    logic              in_fire_s, out_fire_s, any_flush_s;

    assign in_fire_s   = in_valid & in_ready_r;
    assign out_fire_s  = main_valid_r & out_ready;
    assign any_flush_s = |flush;

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;
    assign occupancy = occupancy_r;

    // Next-state of both entries; the state is encoded by the pair of valid bits.
    always_comb begin
        main_valid_s = main_valid_r;
        skid_valid_s = skid_valid_r;
        main_data_s  = main_data_r;
        skid_data_s  = skid_data_r;
        if (any_flush_s) begin
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
                main_data_s = {DATA_W{1'b0}};
                skid_data_s = {DATA_W{1'b0}};
            end else begin
                main_data_s = main_data_r;
                skid_data_s = skid_data_r;
            end
        end else begin
            case ({main_valid_r, skid_valid_r})
                2'b00: begin
                    if (in_fire_s) begin
                        main_valid_s = 1'b1;
                        main_data_s  = in_data;
                    end else begin
                        main_valid_s = 1'b0;
                    end
                end
                2'b10: begin
                    if (in_fire_s && out_fire_s) begin
                        main_data_s = in_data;
                    end else if (in_fire_s) begin
                        skid_valid_s = 1'b1;
                        skid_data_s  = in_data;
                    end else if (out_fire_s) begin
                        main_valid_s = 1'b0;
                    end else begin
                        main_valid_s = 1'b1;
                    end
                end
                2'b11: begin
                    if (out_fire_s) begin
                        main_data_s  = skid_data_r;
                        skid_valid_s = 1'b0;
                    end else begin
                        skid_valid_s = 1'b1;
                    end
                end
                default: begin
                    // Unreachable pairing: fall back to EMPTY.
                    main_valid_s = 1'b0;
                    skid_valid_s = 1'b0;
                end
            endcase
        end
    end

    // State registers; in_ready and occupancy are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            main_data_r  <= {DATA_W{1'b0}};
            skid_data_r  <= {DATA_W{1'b0}};
            in_ready_r   <= 1'b1;
            occupancy_r  <= 2'd0;
        end else begin
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            main_data_r  <= main_data_s;
            skid_data_r  <= skid_data_s;
            in_ready_r   <= ~skid_valid_s;
            occupancy_r  <= {1'b0, main_valid_s} + {1'b0, skid_valid_s};
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        if (en && (v != {PERF_W{1'b1}})) begin
            return v + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt  <= {PERF_W{1'b0}};
            bubble_cnt <= {PERF_W{1'b0}};
            flush_cnt  <= {PERF_W{1'b0}};
        end else begin
            stall_cnt  <= sat_inc(stall_cnt, main_valid_r & ~out_ready);
            bubble_cnt <= sat_inc(bubble_cnt, ~main_valid_r);
            flush_cnt  <= sat_inc(flush_cnt, any_flush_s);
        end
    end
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised inter-stage pipeline register for the pipelined CPU. It replaces hand-written per-stage registers such as IF/ID, ID/EX, EX/LS and LS/WB.
- Carries an opaque payload bus using a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Supports multi-source flush, with optional payload clearing.

Parameters:
- DATA_W, 256: payload width in bits. The instantiating stage concatenates inst, pc, operands and control fields into it.
- FLUSH_N, 3: number of independent flush request inputs.
- CLEAR_ON_FLUSH, 1: 1 = payload registers zeroed on flush; 0 = payload held and only valid is cleared.
- PERF_W, 32: counter width. Used only with the optional feature.

Ports:
- clk, in, 1: clock; all state updates on posedge.
- rst, in, 1: synchronous, active-low reset; sampled at posedge clk.
- in_valid, in, 1: upstream has a beat.
- in_ready, out, 1: stage can accept a beat. Registered; depends only on internal state.
- in_data, in, DATA_W: upstream payload.
- out_valid, out, 1: downstream beat valid.
- out_ready, in, 1: downstream accepts.
- out_data, out, DATA_W: payload to next stage.
- flush, in, FLUSH_N: flush requests, ORed internally.
- occupancy, out, 2: number of valid entries, 0..2.

Behaviour:
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - any_flush = |flush.
- Storage: main entry (data, valid) drives out_*; skid entry (data, valid) is internal.
- in_ready = ~skid_valid.
- out_valid = main_valid.
- out_data = main_data.
- occupancy = main_valid + skid_valid.
- States (encoded by the valid bits): EMPTY (0,0), BUSY (1,0), FULL (1,1). The combination main=0, skid=1 is illegal and never reached.
- Transitions when no flush:
  - EMPTY & in_fire -> BUSY; main <= in_data.
  - BUSY & in_fire & out_fire -> BUSY; main <= in_data.
  - BUSY & in_fire & ~out_fire -> FULL; skid <= in_data, main unchanged.
  - BUSY & ~in_fire & out_fire -> EMPTY.
  - FULL & out_fire -> BUSY; main <= skid_data, skid_valid <= 0.
  - FULL & ~out_fire -> FULL; all held. in_ready = 0, so no capture is possible.
  - Any other combination: hold.
- Latency and throughput:
  - Latency in_fire -> out_valid is 1 cycle when EMPTY.
  - Sustained throughput is 1 beat/cycle with out_ready held high.
  - Ordering is strict FIFO; no beat is lost or duplicated.
- Flush (priority over everything except reset):
  - When any_flush = 1 at a posedge: main_valid <= 0 and skid_valid <= 0, so the next state is EMPTY.
  - A beat with in_fire in the flush cycle is consumed and dropped; upstream is flushed by the same event.
  - out_fire in the flush cycle still counts as delivered to downstream.
  - CLEAR_ON_FLUSH = 1: main_data and skid_data <= 0.
  - CLEAR_ON_FLUSH = 0: data registers are held.
  - in_ready = 1 in the cycle after a flush.
- Reset: rst == 0 at posedge forces:
  - main_valid = skid_valid = 0;
  - main_data = skid_data = 0;
  - so out_valid = 0, out_data = 0, in_ready = 1, occupancy = 0.
- Reset asserted mid-transfer discards both entries regardless of out_ready or flush.
- out_data while out_valid = 0: holds its last value (zero after reset, or after flush with CLEAR_ON_FLUSH = 1). Downstream must ignore it.
- Data registers only load on the transitions listed above. No combinational path from in_data to out_data.
- No combinational path from out_ready to in_ready.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds three outputs, each PERF_W wide, saturating at all-ones, cleared by reset (flush has no effect on them):
  - stall_cnt: counts cycles with out_valid & ~out_ready.
  - bubble_cnt: counts cycles with ~out_valid.
  - flush_cnt: counts cycles with any_flush.
- Undefined: these ports and their logic do not exist. Datapath behaviour is identical either way.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 and in_data=0xA5 -> out_valid=0, out_data=0, in_ready=1, occupancy=0. After rst=1, the first accepted 0xA5 appears on out_data 1 cycle later.
- Streaming: out_ready=1, send 0x1..0x8 back-to-back -> out_data shows 0x1..0x8 on consecutive cycles; in_ready never 0.
- Backpressure: send 0x10, 0x11, 0x12 with out_ready=0 -> 0x10 in main, 0x11 in skid, occupancy=2, in_ready=0, 0x12 held upstream. Raise out_ready -> 0x10, 0x11, 0x12 emitted in order, no loss.
- Flush: in FULL state, pulse flush=3'b100 while in_valid=1 with 0x20 -> next cycle out_valid=0, occupancy=0, in_ready=1, 0x20 never emitted. With CLEAR_ON_FLUSH=1, out_data=0.
- Simultaneous events: in BUSY, assert in_fire (0x30) and out_fire in the same cycle -> state stays BUSY and out_data=0x30 next cycle. Repeat with flush also asserted -> EMPTY.
- PIPE_STAGE_PERF_EN: 5 stall cycles, 2 flushes, 3 idle cycles -> stall_cnt=5, flush_cnt=2, bubble_cnt ≥3. With PERF_W=4, forcing 20 stall cycles leaves stall_cnt=15 (saturated).
